// File: rtl/csa_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder built on one shared 4-bit carry-select adder, one nibble per clock, LSB first.
// Optional signed-overflow output is enabled by defining CSA_SEQ_SIGNED_OVF_EN.

module carry_select_adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Upper pair is precomputed for both carries and selected by the lower pair's carry.
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

    assign sum[1:0]         = lo[1:0];
    assign {cout, sum[3:2]} = lo[2] ? hi1 : hi0;
endmodule

module csa_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
`ifdef CSA_SEQ_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("csa_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef CSA_SEQ_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CW+1:0]    shamt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept;

    assign shamt   = {cnt_q, 2'b00};
    assign a_shift = a_q >> shamt;
    assign b_shift = b_q >> shamt;

    carry_select_adder4bit u_adder (
        .a    (a_shift[3:0]),
        .b    (b_shift[3:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef CSA_SEQ_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        accept  = 1'b0;

        case (state_q)
            S_IDLE: accept = start;
            S_DONE: begin
                state_d = S_IDLE;
                accept  = start;
            end
            S_RUN: begin
                work_d  = (work_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(nib_sum) << shamt);
                carry_d = nib_cout;
                if (cnt_q == CW'(NIB - 1)) begin
                    sum_d   = work_d;
                    cout_d  = nib_cout;
`ifdef CSA_SEQ_SIGNED_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
                    ovf_d   = work_d[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_cout;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d     = A;
            b_d     = B;
            carry_d = Cin;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef CSA_SEQ_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef CSA_SEQ_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign Cout = cout_q;
`ifdef CSA_SEQ_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Bench for csa_nibble_sequencer: a WIDTH=16 and a WIDTH=4 instance, each with a result scoreboard.
// Handshake: start is taken on a rising edge while idle or done; done pulses one cycle with sum/Cout valid.

module tb_csa_nibble_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;
`ifdef CSA_SEQ_SIGNED_OVF_EN
    logic        ovf16, ovf4;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done16_cnt = 0;

    logic [17:0] exp16_q[$];
    logic [5:0]  exp4_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    csa_nibble_sequencer #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start16),
        .A       (a16),
        .B       (b16),
        .Cin     (cin16),
        .busy    (busy16),
        .done    (done16),
        .sum     (sum16),
        .Cout    (cout16)
`ifdef CSA_SEQ_SIGNED_OVF_EN
        ,
        .ovf     (ovf16)
`endif
    );

    csa_nibble_sequencer #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start4),
        .A       (a4),
        .B       (b4),
        .Cin     (cin4),
        .busy    (busy4),
        .done    (done4),
        .sum     (sum4),
        .Cout    (cout4)
`ifdef CSA_SEQ_SIGNED_OVF_EN
        ,
        .ovf     (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {ovf, Cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        int r;
        s = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r = int'($signed(a)) + int'($signed(b)) + int'(c);
        return {(r > 32767) || (r < -32768), s};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] s;
        int r;
        s = {1'b0, a} + {1'b0, b} + {4'd0, c};
        r = int'($signed(a)) + int'($signed(b)) + int'(c);
        return {(r > 7) || (r < -8), s};
    endfunction

    always @(negedge clk) begin
        logic [17:0] e;
        if (done16) begin
            done16_cnt++;
            check("excl16", {31'd0, busy16}, 32'd0);
            check("sb16_nonempty", {31'd0, exp16_q.size() != 0}, 32'd1);
            if (exp16_q.size() != 0) begin
                e = exp16_q.pop_front();
                check("sum16", {16'd0, sum16}, {16'd0, e[15:0]});
                check("cout16", {31'd0, cout16}, {31'd0, e[16]});
`ifdef CSA_SEQ_SIGNED_OVF_EN
                check("ovf16", {31'd0, ovf16}, {31'd0, e[17]});
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (done4) begin
            check("excl4", {31'd0, busy4}, 32'd0);
            check("sb4_nonempty", {31'd0, exp4_q.size() != 0}, 32'd1);
            if (exp4_q.size() != 0) begin
                e = exp4_q.pop_front();
                check("sum_cout4", {27'd0, cout4, sum4}, {27'd0, e[4:0]});
`ifdef CSA_SEQ_SIGNED_OVF_EN
                check("ovf4", {31'd0, ovf4}, {31'd0, e[5]});
`endif
            end
        end
    end

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c);
        start16 = 1'b1;
        a16 = a;
        b16 = b;
        cin16 = c;
        exp16_q.push_back(model16(a, b, c));
        @(posedge clk);
        #1;
        start16 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        cin4 = c;
        exp4_q.push_back(model4(a, b, c));
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    task automatic wait_done16(output int t);
        bit found;
        found = 1'b0;
        t = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (done16) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) check("done16_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, cnt0;
        logic [15:0] va[4];
        logic [15:0] vb[4];
        logic        vc[4];

        reset_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4 = 1'b0;  a4 = '0;  b4 = '0;  cin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy16", {31'd0, busy16}, 32'd0);
        check("rst_done16", {31'd0, done16}, 32'd0);
        check("rst_sum16", {16'd0, sum16}, 32'd0);
        check("rst_cout16", {31'd0, cout16}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic operation with exact latency and busy/done timing
        issue16(16'h1234, 16'h0FFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lat_busy", {31'd0, busy16}, 32'd1);
            check("lat_no_done", {31'd0, done16}, 32'd0);
            check("sum_no_partial", {16'd0, sum16}, 32'd0);
        end
        @(negedge clk);
        check("lat_done", {31'd0, done16}, 32'd1);
        check("lat_done_busy", {31'd0, busy16}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done16}, 32'd0);
        repeat (2) @(negedge clk);
        check("sum_hold_idle", {16'd0, sum16}, 32'h2233);

        // Carry rippling through all nibbles and signed-overflow corners
        va = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        vb = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
        vc = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue16(va[i], vb[i], vc[i]);
            @(negedge clk);
            check("sum_hold_run", {31'd0, busy16}, 32'd1);
            wait_done16(t1);
        end
        issue16(16'h1234, 16'h0FFF, 1'b0);
        wait_done16(t1);

        // start while busy is ignored
        @(posedge clk);
        #1;
        cnt0 = done16_cnt;
        issue16(16'h1234, 16'h0FFF, 1'b0);
        start16 = 1'b1;
        a16 = 16'h0001;
        b16 = 16'h0001;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start16 = 1'b0;
        wait_done16(t1);
        repeat (8) @(posedge clk);
        #1;
        check("one_done_pulse", done16_cnt - cnt0, 32'd1);

        // start held through DONE gives back-to-back operation
        start16 = 1'b1;
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0;
        exp16_q.push_back(model16(16'h1111, 16'h2222, 1'b0));
        @(posedge clk);
        #1;
        a16 = 16'h0F0F; b16 = 16'hF0F1; cin16 = 1'b1;
        exp16_q.push_back(model16(16'h0F0F, 16'hF0F1, 1'b1));
        wait_done16(t1);
        @(posedge clk);
        #1;
        start16 = 1'b0;
        wait_done16(t2);
        check("b2b_gap", t2 - t1, 32'd5);

        // Reset in the middle of RUN aborts without a done pulse
        @(posedge clk);
        #1;
        start16 = 1'b1;
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt0 = done16_cnt;
        @(negedge clk);
        check("abort_busy", {31'd0, busy16}, 32'd0);
        check("abort_done", {31'd0, done16}, 32'd0);
        check("abort_sum", {16'd0, sum16}, 32'd0);
        check("abort_cout", {31'd0, cout16}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", done16_cnt - cnt0, 32'd0);
        issue16(16'h00FF, 16'h0001, 1'b0);
        wait_done16(t1);

        // WIDTH=4 exhaustive, one RUN cycle per operation
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue4(a[3:0], b[3:0], c[0]);
                    @(negedge clk);
                    check("w4_busy", {31'd0, busy4}, 32'd1);
                    @(negedge clk);
                    check("w4_done", {31'd0, done4}, 32'd1);
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb16_empty", exp16_q.size(), 32'd0);
        check("sb4_empty", exp4_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/csa_nibble_sequencer.md
Name: csa_nibble_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands on one shared 4-bit carry_select_adder4bit instance.
- Processes one nibble per clock, least significant nibble first, and registers the carry between nibbles.
- Provides a start/busy/done handshake for wider arithmetic paths in the lab datapath, so no WIDTH-bit adder is instantiated.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. Elaboration fails ($error) otherwise.
- NIB (localparam), WIDTH/4, number of nibble passes. Counter width is $clog2(NIB), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  request; sampled on rising edge in IDLE or DONE only
- A  input  WIDTH  operand A; captured when start is accepted
- B  input  WIDTH  operand B; captured when start is accepted
- Cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum/Cout valid
- sum  output  WIDTH  registered result; held until next completion
- Cout  output  1  registered final carry-out
- ovf  output  1  signed overflow (only with SIGNED_OVF_EN)

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low, on reset_n. Reset wins over every other event.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, Cout = 0, ovf = 0
  - operand, working and carry registers = 0
  - nibble counter = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge k: latch A, B and Cin (Cin goes to the carry register), clear the counter, go to RUN.
  - start = 0: stay in IDLE.
- RUN (busy = 1): on each edge, the adder gets A_reg[4i+3:4i], B_reg[4i+3:4i] and the carry register, where i = counter.
  - Adder sum is written to work[4i+3:4i]; adder Cout is written to the carry register.
  - If i < NIB-1: counter increments.
  - If i = NIB-1: copy work (with the final nibble included) to sum, copy the final carry to Cout, go to DONE.
- DONE (done = 1 for exactly one cycle):
  - start = 1 on this edge: accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+NIB → next accepted start no earlier than edge k+NIB+1.
  - Throughput is one result per NIB+1 cycles.
- While in RUN:
  - start is ignored.
  - Changes on A, B and Cin have no effect, because operands are captured at acceptance.
- sum and Cout change only on the RUN→DONE edge. They never show partial results and hold their value through IDLE and the following RUN.
- Carry chaining is exact: result equals A + B + Cin mod 2^WIDTH, and Cout equals bit WIDTH of the full sum.
- WIDTH = 4 (NIB = 1): a single RUN cycle, with the same handshake.
- Reset asserted during RUN or DONE:
  - Operation aborts and all outputs return to reset values on that edge.
  - No done pulse is produced for the aborted operation.
- done and busy are never high together.

Optional Feature:
- Macro: CSA_SEQ_SIGNED_OVF_EN.
- Defined:
  - Port ovf exists. On the RUN→DONE edge it is registered as carry_into_MSB XOR final_carry, i.e. two's-complement overflow of A + B + Cin.
  - It holds with sum. Reset value is 0.
- Undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0FFF, Cin=0, start pulsed at edge k → busy high during edges k+1..k+4; done high only after edge k+4; sum=0x2233, Cout=0.
- A=0xFFFF, B=0x0001, Cin=0 → sum=0x0000, Cout=1; then A=0xFFFF, B=0xFFFF, Cin=1 → sum=0xFFFF, Cout=1. Confirms the carry ripples through all 4 nibbles.
- Issue a start while busy, with different operands (A=0x0001, B=0x0001) → ignored, first result unchanged, exactly one done pulse. Also hold start high through DONE → second operation begins immediately, and its done arrives 5 cycles after the first.
- Assert reset_n=0 for one edge in the middle of RUN → busy=0, done=0, sum=0, Cout=0 on the next cycle, and no done pulse follows. A subsequent start with A=0x00FF, B=0x0001 gives sum=0x0100.
- WIDTH=4 build, exhaustive over all A, B and Cin (512 cases) → {Cout,sum} equals A+B+Cin each time; done arrives 1 cycle after acceptance.
- CSA_SEQ_SIGNED_OVF_EN, WIDTH=16:
  - 0x7FFF+0x0001 → ovf=1
  - 0x8000+0xFFFF → ovf=1, Cout=1
  - 0x1234+0x0FFF → ovf=0
